// File: rtl/seq_timer_bank.sv
// Bank of NUM_CH independent timers that count on a shared prescaled tick.
// Each channel supports one-shot or auto-reload mode, pause, abort and retrigger.
// state  | meaning
// S_IDLE | stopped, count 0, waiting for start
// S_RUN  | counting toward tc on each tick
// S_DONE | one-shot reached tc; count holds tc and done is set
module seq_timer_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 1,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH-1:0]       ch_pause,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_tc,
  input  logic                    cfg_reload,
  output logic                    cfg_err,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_expire,
  output logic [NUM_CH*CNT_W-1:0] ch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [CNT_W-1:0] count_d [NUM_CH];
  logic [CNT_W-1:0] tc_q    [NUM_CH];
  logic [CNT_W-1:0] tc_d    [NUM_CH];
  logic [NUM_CH-1:0] reload_q, reload_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] expire_q, expire_d;
  logic [NUM_CH-1:0] cfg_hit;
  logic              cfg_err_q, cfg_err_d;
  logic              tick;

  if (PRESCALE > 1) begin : g_ps
    localparam int PS_W = $clog2(PRESCALE);
    logic [PS_W-1:0] ps_q;

    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ps_q <= '0;
      else        ps_q <= tick ? '0 : ps_q + PS_W'(1);
    end
  end else begin : g_no_ps
    assign tick = 1'b1;
  end

  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      tc_d[i]     = tc_q[i];
      reload_d[i] = reload_q[i];
      done_d[i]   = done_q[i];
      expire_d[i] = 1'b0;

      // tc_d/reload_d double as the settings for a start in this same cycle
      cfg_hit[i] = cfg_wr && (cfg_ch == CH_W'(i)) && (state_q[i] != S_RUN);
      if (cfg_hit[i]) begin
        tc_d[i]     = cfg_tc;
        reload_d[i] = cfg_reload;
      end

      if (ch_stop[i]) begin
        state_d[i] = S_IDLE;
        count_d[i] = '0;
        done_d[i]  = 1'b0;
      end else if (ch_start[i]) begin
        count_d[i] = '0;
        if (tc_d[i] == '0) begin
          state_d[i]  = S_DONE;
          done_d[i]   = 1'b1;
          expire_d[i] = 1'b1;
        end else begin
          state_d[i] = S_RUN;
          done_d[i]  = 1'b0;
        end
      end else if (state_q[i] == S_RUN && tick && !ch_pause[i]) begin
        if (count_q[i] == tc_q[i] - CNT_W'(1)) begin
          expire_d[i] = 1'b1;
          if (reload_q[i]) begin
            count_d[i] = '0;
          end else begin
            count_d[i] = tc_q[i];
            state_d[i] = S_DONE;
            done_d[i]  = 1'b1;
          end
        end else begin
          count_d[i] = count_q[i] + CNT_W'(1);
        end
      end
    end
    cfg_err_d = cfg_wr && (cfg_hit == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        count_q[i] <= '0;
        tc_q[i]    <= '1;
      end
      reload_q  <= '0;
      done_q    <= '0;
      expire_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
        tc_q[i]    <= tc_d[i];
      end
      reload_q  <= reload_d;
      done_q    <= done_d;
      expire_q  <= expire_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ch_busy[g]                   = (state_q[g] == S_RUN);
    assign ch_count[g*CNT_W +: CNT_W]   = count_q[g];
  end

  assign ch_done   = done_q;
  assign ch_expire = expire_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_timer_bank.sv
// Directed bench for seq_timer_bank: a default instance (4 ch, PRESCALE=1)
// and a 3-channel PRESCALE=4 instance for prescaler and out-of-range config.
module tb_seq_timer_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start, stop, pause;
  logic        cfg_wr, cfg_reload;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_tc;
  logic        cfg_err;
  logic [3:0]  busy, done, expire;
  logic [31:0] count;

  logic [2:0]  p_start, p_stop, p_pause;
  logic        p_cfg_wr, p_cfg_reload;
  logic [1:0]  p_cfg_ch;
  logic [7:0]  p_cfg_tc;
  logic        p_cfg_err;
  logic [2:0]  p_busy, p_done, p_expire;
  logic [23:0] p_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_timer_bank #(.NUM_CH(4), .CNT_W(8), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .ch_start(start), .ch_stop(stop), .ch_pause(pause),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_tc(cfg_tc), .cfg_reload(cfg_reload),
    .cfg_err(cfg_err), .ch_busy(busy), .ch_done(done), .ch_expire(expire),
    .ch_count(count)
  );

  seq_timer_bank #(.NUM_CH(3), .CNT_W(8), .PRESCALE(4)) dut_p (
    .clk(clk), .rst_n(rst_n), .ch_start(p_start), .ch_stop(p_stop), .ch_pause(p_pause),
    .cfg_wr(p_cfg_wr), .cfg_ch(p_cfg_ch), .cfg_tc(p_cfg_tc), .cfg_reload(p_cfg_reload),
    .cfg_err(p_cfg_err), .ch_busy(p_busy), .ch_done(p_done), .ch_expire(p_expire),
    .ch_count(p_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cnt(input int i);
    return count[i*8 +: 8];
  endfunction

  function automatic logic [7:0] pcnt(input int i);
    return p_count[i*8 +: 8];
  endfunction

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    step; step;
    n_checks++;
    if ({cfg_err, busy, done, expire, count} !== 45'd0) begin
      n_fail++; $display("FAIL reset_outputs_held: got %h expected 0", {cfg_err, busy, done, expire, count});
    end
    n_checks++;
    if ({p_cfg_err, p_busy, p_done, p_expire, p_count} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs_p: got %h expected 0", {p_cfg_err, p_busy, p_done, p_expire, p_count});
    end
    rst_n = 1'b1;
    step;
    n_checks++;
    if ({cfg_err, busy, done, expire, count} !== 45'd0) begin
      n_fail++; $display("FAIL reset_outputs_released: got %h expected 0", {cfg_err, busy, done, expire, count});
    end
    start[0] = 1'b1; step; start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 300) begin step; n++; end
    n_checks++;
    if (n != 255) begin
      n_fail++; $display("FAIL reset_default_tc_latency: got %0d expected 255", n);
    end
    n_checks++;
    if (cnt(0) !== 8'd255 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_default_done_state: got count %0d busy %b expected 255 0", cnt(0), busy[0]);
    end
    stop[0] = 1'b1; step; stop[0] = 1'b0;
    n_checks++;
    if (cnt(0) !== 8'd0 || done[0] !== 1'b0) begin
      n_fail++; $display("FAIL stop_clears: got count %0d done %b expected 0 0", cnt(0), done[0]);
    end
  endtask

  task automatic test_oneshot;
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_tc = 8'd5; cfg_reload = 1'b0;
    step; cfg_wr = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_cfg_accept: got cfg_err %b expected 0", cfg_err);
    end
    start[1] = 1'b1; step; start[1] = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b1 || cnt(1) !== 8'd0) begin
      n_fail++; $display("FAIL oneshot_run_entry: got busy %b count %0d expected 1 0", busy[1], cnt(1));
    end
    for (int k = 1; k <= 5; k++) begin
      step;
      n_checks++;
      if (cnt(1) !== 8'(k) || expire[1] !== (k == 5) || done[1] !== (k == 5) || busy[1] !== (k != 5)) begin
        n_fail++;
        $display("FAIL oneshot_step%0d: got count %0d exp %b done %b busy %b expected %0d %b %b %b",
                 k, cnt(1), expire[1], done[1], busy[1], k, k == 5, k == 5, k != 5);
      end
    end
    step; step;
    n_checks++;
    if (expire[1] !== 1'b0 || done[1] !== 1'b1 || busy[1] !== 1'b0 || cnt(1) !== 8'd5) begin
      n_fail++; $display("FAIL oneshot_sticky: got exp %b done %b busy %b count %0d expected 0 1 0 5",
                         expire[1], done[1], busy[1], cnt(1));
    end
  endtask

  task automatic test_reload_pause;
    int c;
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_tc = 8'd3; cfg_reload = 1'b1;
    step; cfg_wr = 1'b0;
    start[2] = 1'b1; step; start[2] = 1'b0;
    c = 0;
    for (int k = 1; k <= 6; k++) begin
      step; c = (c + 1) % 3;
      n_checks++;
      if (cnt(2) !== 8'(c) || expire[2] !== (c == 0) || busy[2] !== 1'b1) begin
        n_fail++; $display("FAIL reload_step%0d: got count %0d exp %b busy %b expected %0d %b 1",
                           k, cnt(2), expire[2], busy[2], c, c == 0);
      end
    end
    pause[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step;
      n_checks++;
      if (cnt(2) !== 8'(c) || expire[2] !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold%0d: got count %0d exp %b expected %0d 0", k, cnt(2), expire[2], c);
      end
    end
    pause[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step; c = (c + 1) % 3;
      n_checks++;
      if (cnt(2) !== 8'(c) || expire[2] !== (c == 0)) begin
        n_fail++; $display("FAIL pause_resume%0d: got count %0d exp %b expected %0d %b",
                           k, cnt(2), expire[2], c, c == 0);
      end
    end
  endtask

  task automatic test_collisions;
    int n;
    // ch2 is still running in reload mode with tc=3
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_tc = 8'd9; cfg_reload = 1'b0;
    step; cfg_wr = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_running_err: got %b expected 1", cfg_err);
    end
    step;
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err_single_cycle: got %b expected 0", cfg_err);
    end
    n = 0;
    while (!expire[2] && n < 10) begin step; n++; end
    step; n = 1;
    while (!expire[2] && n < 20) begin step; n++; end
    n_checks++;
    if (n != 3 || busy[2] !== 1'b1) begin
      n_fail++; $display("FAIL cfg_running_tc_kept: got period %0d busy %b expected 3 1", n, busy[2]);
    end
    stop[2] = 1'b1; step; stop[2] = 1'b0;

    start[3] = 1'b1; step; start[3] = 1'b0; step;
    n_checks++;
    if (cnt(3) !== 8'd1 || busy[3] !== 1'b1) begin
      n_fail++; $display("FAIL ch3_running: got count %0d busy %b expected 1 1", cnt(3), busy[3]);
    end
    start[3] = 1'b1; stop[3] = 1'b1; step; start[3] = 1'b0; stop[3] = 1'b0;
    n_checks++;
    if (busy[3] !== 1'b0 || cnt(3) !== 8'd0 || done[3] !== 1'b0) begin
      n_fail++; $display("FAIL start_stop_collision: got busy %b count %0d done %b expected 0 0 0",
                         busy[3], cnt(3), done[3]);
    end

    start[1] = 1'b1; step; start[1] = 1'b0;
    step; step; step;
    n_checks++;
    if (cnt(1) !== 8'd3) begin
      n_fail++; $display("FAIL retrigger_pre: got count %0d expected 3", cnt(1));
    end
    start[1] = 1'b1; step; start[1] = 1'b0;
    n_checks++;
    if (cnt(1) !== 8'd0 || busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL retrigger_restart: got count %0d busy %b expected 0 1", cnt(1), busy[1]);
    end
    n = 0;
    while (!done[1] && n < 20) begin step; n++; end
    n_checks++;
    if (n != 5) begin
      n_fail++; $display("FAIL retrigger_latency: got %0d expected 5", n);
    end

    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_tc = 8'd2; cfg_reload = 1'b0; start[0] = 1'b1;
    step; cfg_wr = 1'b0; start[0] = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0 || busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL cfg_with_start: got cfg_err %b busy %b expected 0 1", cfg_err, busy[0]);
    end
    n = 0;
    while (!done[0] && n < 20) begin step; n++; end
    n_checks++;
    if (n != 2) begin
      n_fail++; $display("FAIL cfg_with_start_latency: got %0d expected 2", n);
    end

    start[0] = 1'b1; start[1] = 1'b1; step; start[0] = 1'b0; start[1] = 1'b0;
    step; step;
    n_checks++;
    if (done[0] !== 1'b1 || done[1] !== 1'b0 || cnt(1) !== 8'd2) begin
      n_fail++; $display("FAIL multi_ch_a: got done0 %b done1 %b count1 %0d expected 1 0 2", done[0], done[1], cnt(1));
    end
    step; step; step;
    n_checks++;
    if (done[1] !== 1'b1 || cnt(0) !== 8'd2) begin
      n_fail++; $display("FAIL multi_ch_b: got done1 %b count0 %0d expected 1 2", done[1], cnt(0));
    end

    p_cfg_wr = 1'b1; p_cfg_ch = 2'd3; p_cfg_tc = 8'd7; p_cfg_reload = 1'b0;
    step; p_cfg_wr = 1'b0;
    n_checks++;
    if (p_cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_out_of_range: got %b expected 1", p_cfg_err);
    end
    step;
    n_checks++;
    if (p_cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL cfg_out_of_range_pulse: got %b expected 0", p_cfg_err);
    end
  endtask

  task automatic test_prescale;
    int n, n1;
    p_cfg_wr = 1'b1; p_cfg_ch = 2'd0; p_cfg_tc = 8'd2; p_cfg_reload = 1'b0;
    step; p_cfg_wr = 1'b0;
    p_start[0] = 1'b1; step; p_start[0] = 1'b0;
    n = 0; n1 = -1;
    while (!p_done[0] && n < 20) begin
      step; n++;
      if (pcnt(0) == 8'd1 && n1 < 0) n1 = n;
    end
    n_checks++;
    if (n < 5 || n > 8) begin
      n_fail++; $display("FAIL prescale_latency: got %0d expected 5..8", n);
    end
    n_checks++;
    if (n - n1 != 4 || pcnt(0) !== 8'd2) begin
      n_fail++; $display("FAIL prescale_tick_spacing: got %0d count %0d expected 4 2", n - n1, pcnt(0));
    end

    p_cfg_wr = 1'b1; p_cfg_ch = 2'd1; p_cfg_tc = 8'd0; p_cfg_reload = 1'b1;
    step; p_cfg_wr = 1'b0;
    p_start[1] = 1'b1; step; p_start[1] = 1'b0;
    n_checks++;
    if (p_done[1] !== 1'b1 || p_expire[1] !== 1'b1 || p_busy[1] !== 1'b0 || pcnt(1) !== 8'd0) begin
      n_fail++; $display("FAIL tc0_start: got done %b exp %b busy %b count %0d expected 1 1 0 0",
                         p_done[1], p_expire[1], p_busy[1], pcnt(1));
    end
    step;
    n_checks++;
    if (p_expire[1] !== 1'b0 || p_done[1] !== 1'b1) begin
      n_fail++; $display("FAIL tc0_single_pulse: got exp %b done %b expected 0 1", p_expire[1], p_done[1]);
    end
  endtask

  task automatic test_async_reset;
    int n;
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_tc = 8'd20; cfg_reload = 1'b0;
    step; cfg_wr = 1'b0;
    start[0] = 1'b1; step; start[0] = 1'b0;
    for (int k = 0; k < 7; k++) step;
    n_checks++;
    if (cnt(0) !== 8'd7) begin
      n_fail++; $display("FAIL async_pre_count: got %0d expected 7", cnt(0));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_err, busy, done, expire, count} !== 45'd0 ||
        {p_cfg_err, p_busy, p_done, p_expire, p_count} !== 34'd0) begin
      n_fail++; $display("FAIL async_reset_immediate: got %h %h expected 0 0",
                         {cfg_err, busy, done, expire, count}, {p_cfg_err, p_busy, p_done, p_expire, p_count});
    end
    step; step;
    rst_n = 1'b1;
    step; step; step;
    n_checks++;
    if (busy[0] !== 1'b0 || cnt(0) !== 8'd0 || done[0] !== 1'b0) begin
      n_fail++; $display("FAIL async_idle_after: got busy %b count %0d done %b expected 0 0 0",
                         busy[0], cnt(0), done[0]);
    end
    start[0] = 1'b1; step; start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 300) begin step; n++; end
    n_checks++;
    if (n != 255) begin
      n_fail++; $display("FAIL async_tc_restored: got %0d expected 255", n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0; stop = '0; pause = '0;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_tc = '0; cfg_reload = 1'b0;
    p_start = '0; p_stop = '0; p_pause = '0;
    p_cfg_wr = 1'b0; p_cfg_ch = '0; p_cfg_tc = '0; p_cfg_reload = 1'b0;
    test_reset;
    test_oneshot;
    test_reload_pause;
    test_collisions;
    test_prescale;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
